// File: rtl/wb_pkg.sv
// Shared write-back definitions: source indices, the exception-handler constant
// and the select-width helper used by the write-back queue.
package wb_pkg;

  localparam int          DEST_W_DEF    = 5;
  localparam logic [31:0] CONST_EXC_VEC = 32'd227;

  localparam int SRC_ALU   = 0;
  localparam int SRC_HILO  = 1;
  localparam int SRC_MEM   = 2;
  localparam int SRC_PC4   = 3;
  localparam int SRC_SHIFT = 4;
  localparam int SRC_LUI   = 5;
  localparam int SRC_CP0   = 6;
  localparam int SRC_IMM   = 7;

  typedef enum logic [1:0] {
    DEC_SRC     = 2'd0,
    DEC_CONST   = 2'd1,
    DEC_ILLEGAL = 2'd2
  } dec_kind_e;

  // Bits needed to encode n sources plus the constant slot.
  function automatic int sel_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic register-based synchronous FIFO; head entry is presented combinationally
// from storage and forced to zero while empty.
module wb_fifo #(
  parameter int   WIDTH = 37,
  parameter int   DEPTH = 4,
  localparam int  AW    = $clog2(DEPTH),
  localparam int  LVL_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives free wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/wb_data_queue.sv
// Write-back source selector for the multicycle datapath: picks a source or the
// exception constant, tags it with a destination and queues it for the register bank.
module wb_data_queue
  import wb_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_SRC   = 8,
  parameter logic [DATA_W-1:0] CONST_VAL = DATA_W'(CONST_EXC_VEC),
  parameter int                DEPTH     = 4,
  parameter int                DEST_W    = DEST_W_DEF,
  parameter bit                DROP_R0   = 1'b1,
  localparam int               SEL_W     = sel_w(NUM_SRC),
  localparam int               LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DEST_W-1:0]         in_dest,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [DEST_W-1:0]         out_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_sel,
  output logic [SEL_W-1:0]          err_code,
  input  logic                      err_clr,
  output logic [LVL_W-1:0]          level
);

  localparam int ENTRY_W = DATA_W + DEST_W;

  logic [DATA_W-1:0]  src_arr [NUM_SRC];
  logic [DATA_W-1:0]  sel_data;
  dec_kind_e          dec_kind;
  logic               accept, drop, push;
  logic               full, empty;
  logic [ENTRY_W-1:0] head;
  logic               err_sel_q, err_sel_d;
  logic [SEL_W-1:0]   err_code_q, err_code_d;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = src_data[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    dec_kind = DEC_ILLEGAL;
    sel_data = '0;
    if (in_sel == SEL_W'(NUM_SRC)) begin
      dec_kind = DEC_CONST;
      sel_data = CONST_VAL;
    end else if (in_sel < SEL_W'(NUM_SRC)) begin
      dec_kind = DEC_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (in_sel == SEL_W'(i)) sel_data = src_arr[i];
      end
    end
  end

  // An illegal select is reported even when the destination is r0.
  assign in_ready = ~full;
  assign accept   = in_valid & in_ready;
  assign drop     = DROP_R0 && (in_dest == '0);
  assign push     = accept && (dec_kind != DEC_ILLEGAL) && !drop;

  // A new illegal select overrides a same-cycle clear and reloads the code.
  always_comb begin
    err_sel_d  = err_sel_q;
    err_code_d = err_code_q;
    if (err_clr) begin
      err_sel_d  = 1'b0;
      err_code_d = '0;
    end
    if (accept && (dec_kind == DEC_ILLEGAL)) begin
      err_sel_d = 1'b1;
      if (!err_sel_q || err_clr) err_code_d = in_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sel_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      err_sel_q  <= err_sel_d;
      err_code_q <= err_code_d;
    end
  end

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (out_ready),
    .wdata_i ({sel_data, in_dest}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign out_valid = ~empty;
  assign out_data  = head[ENTRY_W-1:DEST_W];
  assign out_dest  = head[DEST_W-1:0];
  assign err_sel   = err_sel_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_wb_data_queue.sv
// Directed bench for wb_data_queue with immediate-assertion checks.
module tb_wb_data_queue;

  logic         clk;
  logic         reset_n;
  logic [255:0] src_data;
  logic [3:0]   in_sel;
  logic [4:0]   in_dest;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [4:0]   out_dest;
  logic         out_valid;
  logic         out_ready;
  logic         err_sel;
  logic [3:0]   err_code;
  logic         err_clr;
  logic [2:0]   level;

  int vectors;
  int miscompares;

  wb_data_queue dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_data  (src_data),
    .in_sel    (in_sel),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .err_code  (err_code),
    .err_clr   (err_clr),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    src_data    = '0;
    in_sel      = '0;
    in_dest     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    err_clr     = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_out_dest",  32'(out_dest),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_err_sel",   32'(err_sel),   32'd0);
    chk("rst_err_code",  32'(err_code),  32'd0);
    chk("rst_level",     32'(level),     32'd0);
    reset_n = 1'b1;
    step();

    // Basic source 0 path, no combinational bypass before the edge
    src_data[31:0] = 32'hDEADBEEF;
    in_sel = 4'd0; in_dest = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_no_bypass", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data",  out_data,       32'hDEADBEEF);
    chk("t1_dest",  32'(out_dest),  32'd3);
    step();
    chk("t1_popped", 32'(level), 32'd0);

    // Constant slot and illegal selects
    in_sel = 4'd8; in_dest = 5'd31; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_const_data", out_data,      32'd227);
    chk("t2_const_dest", 32'(out_dest), 32'd31);
    step();
    in_sel = 4'd9; in_dest = 5'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_err_sel",  32'(err_sel),   32'd1);
    chk("t2_err_code", 32'(err_code),  32'd9);
    chk("t2_no_enq",   32'(out_valid), 32'd0);
    in_sel = 4'd12; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_code_kept", 32'(err_code), 32'd9);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t2_clr_sel",  32'(err_sel),  32'd0);
    chk("t2_clr_code", 32'(err_code), 32'd0);
    in_sel = 4'd10; in_valid = 1'b1;
    step();
    in_sel = 4'd11; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("t2_clr_vs_new_sel",  32'(err_sel),  32'd1);
    chk("t2_clr_vs_new_code", 32'(err_code), 32'd11);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t2_final_clr", 32'(err_sel), 32'd0);

    // Fill to full with out_ready low; the fifth request is refused
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = 32'h1000 + i;
    for (int k = 0; k < 5; k++) begin
      in_sel = 4'(k + 1); in_dest = 5'(k + 1); in_valid = 1'b1;
      chk($sformatf("t3_in_ready_%0d", k), 32'(in_ready), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) src_data[i*32 +: 32] = 32'hBAD0 + i;
    chk("t3_level_full", 32'(level),    32'd4);
    chk("t3_not_ready",  32'(in_ready), 32'd0);
    step();
    chk("t3_head_stable", out_data, 32'h1001);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_order_data_%0d", k), out_data,      32'h1000 + k + 1);
      chk($sformatf("t3_order_dest_%0d", k), 32'(out_dest), 32'(k + 1));
      step();
    end
    chk("t3_drained", 32'(level), 32'd0);

    // Full queue with simultaneous request and pop: pop only
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_sel = 4'd8; in_dest = 5'(10 + k); in_valid = 1'b1;
      step();
    end
    src_data[31:0] = 32'h55;
    in_sel = 4'd0; in_dest = 5'd20; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_pop_only_level", 32'(level),    32'd3);
    chk("t4_ready_again",    32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_push_after", 32'(level), 32'd4);
    out_ready = 1'b1;
    chk("t4_head0", 32'(out_dest), 32'd11);
    step();
    chk("t4_head1", 32'(out_dest), 32'd12);
    step();
    chk("t4_head2", 32'(out_dest), 32'd13);
    step();
    chk("t4_head3_dest", 32'(out_dest), 32'd20);
    chk("t4_head3_data", out_data,      32'h55);
    step();
    chk("t4_empty", 32'(out_valid), 32'd0);

    // r0 destination is consumed silently
    out_ready = 1'b0;
    in_sel = 4'd2; in_dest = 5'd0; in_valid = 1'b1;
    chk("t5_ready", 32'(in_ready), 32'd1);
    step();
    chk("t5_drop_level", 32'(level),   32'd0);
    chk("t5_drop_noerr", 32'(err_sel), 32'd0);
    in_dest = 5'd1;
    step();
    in_valid = 1'b0;
    chk("t5_r1_level", 32'(level),    32'd1);
    chk("t5_r1_dest",  32'(out_dest), 32'd1);
    chk("t5_r1_data",  out_data,      32'hBAD2);

    // Asynchronous reset mid-cycle with three entries and a pending error
    in_sel = 4'd3; in_dest = 5'd7; in_valid = 1'b1;
    step();
    step();
    in_sel = 4'd15;
    step();
    in_valid = 1'b0;
    chk("t6_pre_level", 32'(level),   32'd3);
    chk("t6_pre_err",   32'(err_sel), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_valid",    32'(out_valid), 32'd0);
    chk("t6_level",    32'(level),     32'd0);
    chk("t6_in_ready", 32'(in_ready),  32'd1);
    chk("t6_data",     out_data,       32'd0);
    chk("t6_err",      32'(err_sel),   32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("t6_post_level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
